// File: rtl/identity_check_pkg.sv
// Shared definitions for the identity-check sequencer: default sizing,
// sweep state encoding and a helper that sizes the settle timer.
package identity_check_pkg;

    localparam int DEF_NVARS         = 4;
    localparam int DEF_NPAIRS        = 3;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_CNT_W         = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // The timer only ever holds SETTLE_CYCLES-1, so log2 of SETTLE_CYCLES
    // bits suffice; a single bit is kept when one settle cycle is requested.
    function automatic int timerWidth(input int settleCycles);
        return (settleCycles > 1) ? $clog2(settleCycles) : 1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that measures how long a vector has been held
// before the sequencer samples the unit under check.
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_loadVal,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Reload wins over counting down, and the count parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/identity_check_sequencer.sv
// Walks a combinational Boolean-identity unit through every input
// combination, lets each vector settle, then compares its lhs/rhs pairs
// and accumulates mismatch statistics for the lab top level.
module identity_check_sequencer
    import identity_check_pkg::*;
#(
    parameter int NVARS         = DEF_NVARS,
    parameter int NPAIRS        = DEF_NPAIRS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [NVARS-1:0]  vec_out,
    input  logic [NPAIRS-1:0] lhs_in,
    input  logic [NPAIRS-1:0] rhs_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [NPAIRS-1:0] err_mask,
    output logic              first_fail_valid,
    output logic [NVARS-1:0]  first_fail_vec
);

    localparam int TW = timerWidth(SETTLE_CYCLES);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

    state_t            r_state;
    logic [NVARS-1:0]  r_vec;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [CNT_W-1:0]  r_mismatchCnt;
    logic [NPAIRS-1:0] r_errMask;
    logic              r_firstFailValid;
    logic [NVARS-1:0]  r_firstFailVec;

    logic [NPAIRS-1:0] w_diff;
    logic              w_anyDiff;
    logic              w_lastVec;
    logic              w_cntSat;
    logic              w_accept;
    logic              w_timerLoad;
    logic              w_timerDec;
    logic              w_timerZero;

    assign w_diff      = lhs_in ^ rhs_in;
    assign w_anyDiff   = (w_diff != '0);
    assign w_lastVec   = (r_vec == '1);
    assign w_cntSat    = (r_mismatchCnt == '1);
    assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_timerLoad = w_accept || ((r_state == ST_SAMPLE) && !w_lastVec);
    assign w_timerDec  = (r_state == ST_SETTLE);

    settle_timer #(
        .W(TW)
    ) u_settleTimer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_timerLoad),
        .i_loadVal(SETTLE_LOAD),
        .i_dec    (w_timerDec),
        .o_zero   (w_timerZero)
    );

    // Sweep controller: arms on start, holds each vector, samples once, and accumulates results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_vec            <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_mismatchCnt    <= '0;
            r_errMask        <= '0;
            r_firstFailValid <= 1'b0;
            r_firstFailVec   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state          <= ST_SETTLE;
                        r_vec            <= '0;
                        r_busy           <= 1'b1;
                        r_done           <= 1'b0;
                        r_pass           <= 1'b0;
                        r_mismatchCnt    <= '0;
                        r_errMask        <= '0;
                        r_firstFailValid <= 1'b0;
                        r_firstFailVec   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (w_timerZero) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_errMask <= r_errMask | w_diff;
                    if (w_anyDiff) begin
                        if (!w_cntSat) begin
                            r_mismatchCnt <= r_mismatchCnt + CNT_W'(1);
                        end
                        if (!r_firstFailValid) begin
                            r_firstFailValid <= 1'b1;
                            r_firstFailVec   <= r_vec;
                        end
                    end
                    if (w_lastVec) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_mismatchCnt == '0) && !w_anyDiff;
                    end else begin
                        r_vec   <= r_vec + NVARS'(1);
                        r_state <= ST_SETTLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vec_out          = r_vec;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign mismatch_cnt     = r_mismatchCnt;
    assign err_mask         = r_errMask;
    assign first_fail_valid = r_firstFailValid;
    assign first_fail_vec   = r_firstFailVec;

endmodule

// File: tb/tb_identity_check_sequencer.sv
// Bench for the identity-check sequencer: a table-driven model of the unit
// under check feeds the sequencer, and expected sweep results come from a
// direct scan of the same table.
module tb_identity_check_sequencer;

    localparam int NV   = 4;
    localparam int NP   = 3;
    localparam int NVEC = 16;
    localparam int TR   = 56;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start2;

    // Free-running clock shared by both sequencer instances.
    always #5 clk = ~clk;

    logic [NV-1:0] vecOut, vecOut2, firstFailVec, firstFailVec2;
    logic [NP-1:0] lhsIn, rhsIn, lhsIn2, rhsIn2, errMask, errMask2;
    logic          busy, done, pass, firstFailValid;
    logic          busy2, done2, pass2, firstFailValid2;
    logic [4:0]    mismatchCnt;
    logic [1:0]    mismatchCnt2;

    logic [NP-1:0] lhsTable  [NVEC];
    logic [NP-1:0] diffTable [NVEC];
    logic [NP-1:0] diffTable2[NVEC];

    assign lhsIn  = lhsTable[vecOut];
    assign rhsIn  = lhsIn ^ diffTable[vecOut];
    assign lhsIn2 = 3'b101;
    assign rhsIn2 = lhsIn2 ^ diffTable2[vecOut2];

    identity_check_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .vec_out(vecOut),
        .lhs_in(lhsIn), .rhs_in(rhsIn), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatchCnt), .err_mask(errMask),
        .first_fail_valid(firstFailValid), .first_fail_vec(firstFailVec)
    );

    identity_check_sequencer #(
        .NVARS(4), .NPAIRS(3), .SETTLE_CYCLES(1), .CNT_W(2)
    ) dutShort (
        .clk(clk), .rst(rst), .start(start2), .vec_out(vecOut2),
        .lhs_in(lhsIn2), .rhs_in(rhsIn2), .busy(busy2), .done(done2), .pass(pass2),
        .mismatch_cnt(mismatchCnt2), .err_mask(errMask2),
        .first_fail_valid(firstFailValid2), .first_fail_vec(firstFailVec2)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [NV-1:0] vecTr [TR];
    logic          doneTr[TR];
    logic          busyTr[TR];
    logic [4:0]    cntTr [TR];
    logic [NP-1:0] maskTr[TR];
    int            doneAt;

    int            expCnt;
    logic [NP-1:0] expMask;
    logic          expFfv;
    logic [NV-1:0] expFfVec;
    logic          expPass;

    // Builds the unit-under-check table: 0 identity holds, 1 pair 1 broken at vector 6,
    // 2 every pair broken everywhere, 3 random sparse faults.
    task automatic setTable(input int mode);
        for (int v = 0; v < NVEC; v++) begin
            lhsTable[v] = NP'($urandom);
            case (mode)
                0: diffTable[v] = '0;
                1: diffTable[v] = (v == 6) ? 3'b010 : 3'b000;
                2: diffTable[v] = 3'b111;
                default: diffTable[v] = ($urandom_range(0, 3) == 0) ? NP'($urandom) : 3'b000;
            endcase
        end
    endtask

    // Expected sweep results straight from the fault table.
    task automatic modelSweep(input int which, input int cntMax);
        int n;
        logic [NP-1:0] d;
        n = 0;
        expMask = '0;
        expFfv = 1'b0;
        expFfVec = '0;
        for (int v = 0; v < NVEC; v++) begin
            d = (which == 1) ? diffTable[v] : diffTable2[v];
            expMask = expMask | d;
            if (d != '0) begin
                n++;
                if (!expFfv) begin
                    expFfv = 1'b1;
                    expFfVec = NV'(v);
                end
            end
        end
        expCnt = (n > cntMax) ? cntMax : n;
        expPass = (n == 0);
    endtask

    // Pulses start on the chosen instance and records its outputs for TR cycles.
    task automatic applyStimulus(input int sel, input int pokeStartAt);
        @(negedge clk);
        if (sel == 1) start = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        doneAt = -1;
        for (int j = 0; j < TR; j++) begin
            if (sel == 1) begin
                start = (j == pokeStartAt);
                vecTr[j] = vecOut; doneTr[j] = done; busyTr[j] = busy;
                cntTr[j] = mismatchCnt; maskTr[j] = errMask;
            end else begin
                start2 = (j == pokeStartAt);
                vecTr[j] = vecOut2; doneTr[j] = done2; busyTr[j] = busy2;
                cntTr[j] = {3'b000, mismatchCnt2}; maskTr[j] = errMask2;
            end
            if (doneTr[j] === 1'b1 && doneAt < 0) doneAt = j;
            @(negedge clk);
        end
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++; if (vecOut !== '0) begin miscompares++; $display("[TB] FAIL reset vec_out got %0d want 0", vecOut); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset done got %b want 0", done); end
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("[TB] FAIL reset pass got %b want 0", pass); end
        vectors++; if (mismatchCnt !== '0) begin miscompares++; $display("[TB] FAIL reset mismatch_cnt got %0d want 0", mismatchCnt); end
        vectors++; if (errMask !== '0) begin miscompares++; $display("[TB] FAIL reset err_mask got %b want 000", errMask); end
        vectors++; if (firstFailValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset first_fail_valid got %b want 0", firstFailValid); end
        vectors++; if (firstFailVec !== '0) begin miscompares++; $display("[TB] FAIL reset first_fail_vec got %0d want 0", firstFailVec); end
        vectors++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset short busy/done got %b%b want 00", busy2, done2); end
    endtask

    task automatic test_clean_sweep();
        setTable(0);
        applyStimulus(1, -1);
        modelSweep(1, 31);
        for (int j = 0; j < TR; j++) begin
            vectors++;
            if (vecTr[j] !== ((j < 48) ? NV'(j / 3) : 4'd15)) begin
                miscompares++; $display("[TB] FAIL clean vec_out[%0d] got %0d want %0d", j, vecTr[j], (j < 48) ? j / 3 : 15);
            end
            vectors++;
            if (busyTr[j] !== (j < 48) || doneTr[j] !== (j >= 48)) begin
                miscompares++; $display("[TB] FAIL clean busy/done[%0d] got %b%b want %b%b", j, busyTr[j], doneTr[j], j < 48, j >= 48);
            end
        end
        vectors++; if (doneAt !== 48) begin miscompares++; $display("[TB] FAIL clean done_cycle got %0d want 48", doneAt); end
        vectors++; if (pass !== expPass) begin miscompares++; $display("[TB] FAIL clean pass got %b want %b", pass, expPass); end
        vectors++; if (mismatchCnt !== 5'(expCnt)) begin miscompares++; $display("[TB] FAIL clean mismatch_cnt got %0d want %0d", mismatchCnt, expCnt); end
        vectors++; if (errMask !== expMask) begin miscompares++; $display("[TB] FAIL clean err_mask got %b want %b", errMask, expMask); end
        vectors++; if (firstFailValid !== expFfv) begin miscompares++; $display("[TB] FAIL clean first_fail_valid got %b want %b", firstFailValid, expFfv); end
    endtask

    task automatic test_single_fault();
        setTable(1);
        applyStimulus(1, -1);
        modelSweep(1, 31);
        vectors++; if (doneAt !== 48) begin miscompares++; $display("[TB] FAIL fault done_cycle got %0d want 48", doneAt); end
        vectors++; if (mismatchCnt !== 5'(expCnt)) begin miscompares++; $display("[TB] FAIL fault mismatch_cnt got %0d want %0d", mismatchCnt, expCnt); end
        vectors++; if (errMask !== expMask) begin miscompares++; $display("[TB] FAIL fault err_mask got %b want %b", errMask, expMask); end
        vectors++; if (firstFailValid !== expFfv) begin miscompares++; $display("[TB] FAIL fault first_fail_valid got %b want %b", firstFailValid, expFfv); end
        vectors++; if (firstFailVec !== expFfVec) begin miscompares++; $display("[TB] FAIL fault first_fail_vec got %0d want %0d", firstFailVec, expFfVec); end
        vectors++; if (pass !== expPass) begin miscompares++; $display("[TB] FAIL fault pass got %b want %b", pass, expPass); end
    endtask

    task automatic test_all_fail();
        setTable(2);
        applyStimulus(1, -1);
        modelSweep(1, 31);
        vectors++; if (doneAt !== 48) begin miscompares++; $display("[TB] FAIL allfail done_cycle got %0d want 48", doneAt); end
        vectors++; if (mismatchCnt !== 5'(expCnt)) begin miscompares++; $display("[TB] FAIL allfail mismatch_cnt got %0d want %0d", mismatchCnt, expCnt); end
        vectors++; if (errMask !== expMask) begin miscompares++; $display("[TB] FAIL allfail err_mask got %b want %b", errMask, expMask); end
        vectors++; if (firstFailVec !== expFfVec || firstFailValid !== expFfv) begin miscompares++; $display("[TB] FAIL allfail first_fail got %b/%0d want %b/%0d", firstFailValid, firstFailVec, expFfv, expFfVec); end
        vectors++; if (pass !== expPass) begin miscompares++; $display("[TB] FAIL allfail pass got %b want %b", pass, expPass); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            setTable(3);
            applyStimulus(1, -1);
            modelSweep(1, 31);
            vectors++; if (doneAt !== 48) begin miscompares++; $display("[TB] FAIL random%0d done_cycle got %0d want 48", r, doneAt); end
            vectors++; if (mismatchCnt !== 5'(expCnt)) begin miscompares++; $display("[TB] FAIL random%0d mismatch_cnt got %0d want %0d", r, mismatchCnt, expCnt); end
            vectors++; if (errMask !== expMask) begin miscompares++; $display("[TB] FAIL random%0d err_mask got %b want %b", r, errMask, expMask); end
            vectors++; if (firstFailValid !== expFfv) begin miscompares++; $display("[TB] FAIL random%0d first_fail_valid got %b want %b", r, firstFailValid, expFfv); end
            vectors++; if (expFfv && firstFailVec !== expFfVec) begin miscompares++; $display("[TB] FAIL random%0d first_fail_vec got %0d want %0d", r, firstFailVec, expFfVec); end
            vectors++; if (pass !== expPass) begin miscompares++; $display("[TB] FAIL random%0d pass got %b want %b", r, pass, expPass); end
        end
    endtask

    task automatic test_start_ignored();
        setTable(3);
        applyStimulus(1, 10);
        modelSweep(1, 31);
        for (int j = 0; j < 48; j++) begin
            vectors++;
            if (vecTr[j] !== NV'(j / 3)) begin
                miscompares++; $display("[TB] FAIL ignored vec_out[%0d] got %0d want %0d", j, vecTr[j], j / 3);
            end
        end
        vectors++; if (doneAt !== 48) begin miscompares++; $display("[TB] FAIL ignored done_cycle got %0d want 48", doneAt); end
        vectors++; if (mismatchCnt !== 5'(expCnt)) begin miscompares++; $display("[TB] FAIL ignored mismatch_cnt got %0d want %0d", mismatchCnt, expCnt); end
        vectors++; if (errMask !== expMask) begin miscompares++; $display("[TB] FAIL ignored err_mask got %b want %b", errMask, expMask); end
    endtask

    task automatic test_back_to_back();
        setTable(2);
        applyStimulus(1, -1);
        setTable(0);
        applyStimulus(1, -1);
        vectors++; if (cntTr[0] !== 5'd0 || maskTr[0] !== 3'b000) begin miscompares++; $display("[TB] FAIL restart clear cnt/mask got %0d/%b want 0/000", cntTr[0], maskTr[0]); end
        vectors++; if (doneTr[0] !== 1'b0 || busyTr[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL restart done/busy got %b%b want 01", doneTr[0], busyTr[0]); end
        vectors++; if (vecTr[0] !== 4'd0) begin miscompares++; $display("[TB] FAIL restart vec_out got %0d want 0", vecTr[0]); end
        vectors++; if (doneAt !== 48) begin miscompares++; $display("[TB] FAIL restart done_cycle got %0d want 48", doneAt); end
        vectors++; if (pass !== 1'b1 || firstFailValid !== 1'b0) begin miscompares++; $display("[TB] FAIL restart pass/ffv got %b%b want 10", pass, firstFailValid); end
    endtask

    task automatic test_reset_mid();
        setTable(2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        vectors++; if (vecOut !== '0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset vec/busy/done/pass got %0d/%b%b%b want 0/000", vecOut, busy, done, pass);
        end
        vectors++; if (mismatchCnt !== '0 || errMask !== '0) begin
            miscompares++; $display("[TB] FAIL midreset cnt/mask got %0d/%b want 0/000", mismatchCnt, errMask);
        end
        vectors++; if (firstFailValid !== 1'b0 || firstFailVec !== '0) begin
            miscompares++; $display("[TB] FAIL midreset first_fail got %b/%0d want 0/0", firstFailValid, firstFailVec);
        end
        repeat (5) @(negedge clk);
        vectors++; if (vecOut !== '0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset idle vec/busy got %0d/%b want 0/0", vecOut, busy); end
        setTable(0);
        applyStimulus(1, -1);
        vectors++; if (doneAt !== 48) begin miscompares++; $display("[TB] FAIL postreset done_cycle got %0d want 48", doneAt); end
        vectors++; if (pass !== 1'b1 || mismatchCnt !== '0) begin miscompares++; $display("[TB] FAIL postreset pass/cnt got %b/%0d want 1/0", pass, mismatchCnt); end
        @(negedge clk); start = 1'b1; rst = 1'b1;
        @(negedge clk); start = 1'b0; rst = 1'b0;
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            miscompares++; $display("[TB] FAIL startrst busy/done/pass got %b%b%b want 000", busy, done, pass);
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || vecOut !== '0) begin miscompares++; $display("[TB] FAIL startrst idle busy/vec got %b/%0d want 0/0", busy, vecOut); end
    endtask

    task automatic test_short_settle();
        applyStimulus(2, -1);
        modelSweep(2, 3);
        for (int j = 0; j < 32; j++) begin
            vectors++;
            if (vecTr[j] !== NV'(j / 2)) begin
                miscompares++; $display("[TB] FAIL short vec_out[%0d] got %0d want %0d", j, vecTr[j], j / 2);
            end
        end
        vectors++; if (doneAt !== 32) begin miscompares++; $display("[TB] FAIL short done_cycle got %0d want 32", doneAt); end
        vectors++; if (mismatchCnt2 !== 2'(expCnt)) begin miscompares++; $display("[TB] FAIL short mismatch_cnt got %0d want %0d", mismatchCnt2, expCnt); end
        vectors++; if (errMask2 !== expMask) begin miscompares++; $display("[TB] FAIL short err_mask got %b want %b", errMask2, expMask); end
        vectors++; if (firstFailVec2 !== expFfVec || firstFailValid2 !== expFfv) begin miscompares++; $display("[TB] FAIL short first_fail got %b/%0d want %b/%0d", firstFailValid2, firstFailVec2, expFfv, expFfVec); end
        vectors++; if (pass2 !== expPass) begin miscompares++; $display("[TB] FAIL short pass got %b want %b", pass2, expPass); end
    endtask

    // Runs every scenario in order and reports the totals.
    initial begin
        for (int v = 0; v < NVEC; v++) begin
            lhsTable[v] = '0;
            diffTable[v] = '0;
            diffTable2[v] = 3'b111;
        end
        test_reset();
        test_clean_sweep();
        test_single_fault();
        test_all_fail();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_short_settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
